fifo_ctrl: RTL and testbench

Controller that drives the write and read ports of the 8x12 single-clock true dual-port RAM (true_dpram_sclk / _str), so that the pair forms a FIFO. It accepts push/pop requests from the transaction-layer side and generates wr_e/wr_ptr/data_w and rd_e/rd_ptr. It returns read data with a valid strobe, and maintains occupancy, full/empty, almost-full/almost-empty and a sticky error flag.

---
 rtl/fifo_ctrl_if.sv | 45 ++++
 rtl/fifo_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// ============================================================================
// Module      : fifo_ctrl_if
// Description : Request, status and RAM-port signals of the FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_ctrl_if #(
    parameter int LINE_SIZE    = 12,
    parameter int ADDRESS_SIZE = 3
);
    logic                    push;
    logic [LINE_SIZE-1:0]    data_in;
    logic                    pop;
    logic [ADDRESS_SIZE:0]   af_thresh;
    logic [ADDRESS_SIZE:0]   ae_thresh;
    logic [LINE_SIZE-1:0]    q_r;
    logic                    wr_e;
    logic [ADDRESS_SIZE-1:0] wr_ptr;
    logic [LINE_SIZE-1:0]    data_w;
    logic                    rd_e;
    logic [ADDRESS_SIZE-1:0] rd_ptr;
    logic [LINE_SIZE-1:0]    data_out;
    logic                    valid_out;
    logic [ADDRESS_SIZE:0]   fifo_count;
    logic                    full;
    logic                    empty;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    error;

    modport master (
        output push, data_in, pop, af_thresh, ae_thresh, q_r,
        input  wr_e, wr_ptr, data_w, rd_e, rd_ptr, data_out, valid_out,
               fifo_count, full, empty, almost_full, almost_empty, error
    );

    modport slave (
        input  push, data_in, pop, af_thresh, ae_thresh, q_r,
        output wr_e, wr_ptr, data_w, rd_e, rd_ptr, data_out, valid_out,
               fifo_count, full, empty, almost_full, almost_empty, error
    );
endinterface

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module      : fifo_ctrl
// Description : FIFO controller driving a single-clock true dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl #(
    parameter int LINE_SIZE    = 12,
    parameter int ADDRESS_SIZE = 3
) (
    input  logic       clk,
    input  logic       reset,
    fifo_ctrl_if.slave bus
);
    localparam logic [ADDRESS_SIZE:0] c_DEPTH = (ADDRESS_SIZE + 1)'(2 ** ADDRESS_SIZE);

    logic [ADDRESS_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESS_SIZE:0]   count_q, count_d;
    logic                    valid_q;
    logic                    error_q, error_d;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_wr_e;
    logic                    w_rd_e;
    logic                    w_overflow;
    logic                    w_underflow;
    logic [LINE_SIZE-1:0]    w_data_w;

    assign w_full      = (count_q == c_DEPTH);
    assign w_empty     = (count_q == '0);
    // A pop on a full FIFO frees the slot being written, so the push is accepted.
    assign w_wr_e      = bus.push & (~w_full | bus.pop);
    assign w_rd_e      = bus.pop & ~w_empty;
    assign w_overflow  = bus.push & w_full & ~bus.pop;
    assign w_underflow = bus.pop & w_empty;
    assign w_data_w    = bus.data_in;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q | w_overflow | w_underflow;
        if (w_wr_e) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_e) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_wr_e, w_rd_e})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= w_rd_e;
            error_q  <= error_d;
        end
    end

    assign bus.wr_e         = w_wr_e;
    assign bus.wr_ptr       = wr_ptr_q;
    assign bus.data_w       = w_data_w;
    assign bus.rd_e         = w_rd_e;
    assign bus.rd_ptr       = rd_ptr_q;
    // RAM read data arrives one cycle after rd_e, aligned with valid_q.
    assign bus.data_out     = bus.q_r;
    assign bus.valid_out    = valid_q;
    assign bus.fifo_count   = count_q;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (count_q >= bus.af_thresh);
    assign bus.almost_empty = (count_q <= bus.ae_thresh);
    assign bus.error        = error_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Self-checking bench for fifo_ctrl with a RAM model and a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;
    logic clk;
    logic reset;

    fifo_ctrl_if #(.LINE_SIZE(12), .ADDRESS_SIZE(3)) b ();

    fifo_ctrl #(.LINE_SIZE(12), .ADDRESS_SIZE(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    int total = 0;
    int bad   = 0;

    // FIFO model: queue of words plus expected pointers and flags.
    logic [11:0] mq[$];
    int          m_wr    = 0;
    int          m_rd    = 0;
    bit          m_err   = 0;
    bit          m_valid = 0;
    logic [11:0] m_data  = '0;
    int          n;
    bit          aw, ar;

    logic [11:0] mem [0:7];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Read-before-write RAM behaviour for the 8x12 dual-port memory.
    always @(posedge clk) begin
        if (b.rd_e) b.q_r <= mem[b.rd_ptr];
        if (b.wr_e) mem[b.wr_ptr] <= b.data_w;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare at the falling edge, then advance the model with the inputs
    // that will be sampled at the following rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                m_wr    = 0;
                m_rd    = 0;
                m_err   = 0;
                m_valid = 0;
            end else begin
                n = mq.size();
                chk("count", 32'(b.fifo_count), 32'(n));
                chk("full", 32'(b.full), 32'(n == 8));
                chk("empty", 32'(b.empty), 32'(n == 0));
                chk("almost_full", 32'(b.almost_full), 32'(n >= int'(b.af_thresh)));
                chk("almost_empty", 32'(b.almost_empty), 32'(n <= int'(b.ae_thresh)));
                chk("error", 32'(b.error), 32'(m_err));
                chk("valid_out", 32'(b.valid_out), 32'(m_valid));
                if (m_valid) chk("data_out", 32'(b.data_out), 32'(m_data));
                aw = b.push && (n < 8 || b.pop);
                ar = b.pop && n > 0;
                chk("wr_e", 32'(b.wr_e), 32'(aw));
                chk("rd_e", 32'(b.rd_e), 32'(ar));
                chk("wr_ptr", 32'(b.wr_ptr), 32'(m_wr));
                chk("rd_ptr", 32'(b.rd_ptr), 32'(m_rd));
                if (aw) chk("data_w", 32'(b.data_w), 32'(b.data_in));
                if ((b.push && n == 8 && !b.pop) || (b.pop && n == 0)) m_err = 1;
                m_valid = ar;
                if (ar) begin
                    m_data = mq.pop_front();
                    m_rd   = (m_rd + 1) % 8;
                end
                if (aw) begin
                    mq.push_back(b.data_in);
                    m_wr = (m_wr + 1) % 8;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic p, input logic [11:0] d, input logic pp);
        b.push    = p;
        b.data_in = d;
        b.pop     = pp;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        b.push = 1'b0;
        b.pop  = 1'b0;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        b.push      = 1'b0;
        b.pop       = 1'b0;
        b.data_in   = '0;
        b.af_thresh = 4'd6;
        b.ae_thresh = 4'd2;
        #1;
        do_reset();

        chk("rst_count", 32'(b.fifo_count), 32'd0);
        chk("rst_empty", 32'(b.empty), 32'd1);
        chk("rst_full", 32'(b.full), 32'd0);
        chk("rst_almost_empty", 32'(b.almost_empty), 32'd1);
        chk("rst_almost_full", 32'(b.almost_full), 32'd0);
        chk("rst_error", 32'(b.error), 32'd0);
        chk("rst_valid", 32'(b.valid_out), 32'd0);

        // Fill with 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 12'(i), 1'b0);
            if (i == 5) chk("af_at5", 32'(b.almost_full), 32'd0);
            if (i == 6) chk("af_at6", 32'(b.almost_full), 32'd1);
        end
        chk("fill_full", 32'(b.full), 32'd1);
        chk("fill_count", 32'(b.fifo_count), 32'd8);

        // Overflow attempt
        b.push    = 1'b1;
        b.data_in = 12'h0FF;
        b.pop     = 1'b0;
        #1;
        chk("ovf_wr_e", 32'(b.wr_e), 32'd0);
        @(posedge clk);
        #1;
        chk("ovf_error", 32'(b.error), 32'd1);
        chk("ovf_wr_ptr", 32'(b.wr_ptr), 32'd0);
        chk("ovf_count", 32'(b.fifo_count), 32'd8);

        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 12'h000, 1'b1);
            chk("drain_valid", 32'(b.valid_out), 32'd1);
            chk("drain_data", 32'(b.data_out), 32'(i));
        end
        step(1'b0, 12'h000, 1'b0);
        chk("drain_empty", 32'(b.empty), 32'd1);
        chk("error_sticky", 32'(b.error), 32'd1);

        // Underflow after reset
        do_reset();
        b.pop = 1'b1;
        #1;
        chk("udf_rd_e", 32'(b.rd_e), 32'd0);
        @(posedge clk);
        #1;
        chk("udf_valid", 32'(b.valid_out), 32'd0);
        chk("udf_error", 32'(b.error), 32'd1);
        step(1'b0, 12'h000, 1'b0);

        // Wrap-around
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 12'(12'h100 + i), 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 12'h000, 1'b1);
            if (i == 1) chk("wrap_first", 32'(b.data_out), 32'h101);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 12'(12'hA00 + i), 1'b0);
        chk("wrap_wr_ptr", 32'(b.wr_ptr), 32'd3);
        chk("wrap_count", 32'(b.fifo_count), 32'd6);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 12'h000, 1'b1);
            chk("wrap_pop", 32'(b.data_out), 32'(12'hA00 + i));
        end
        step(1'b1, 12'hB00, 1'b1);
        chk("both3_count", 32'(b.fifo_count), 32'd3);
        chk("both3_data", 32'(b.data_out), 32'hA03);
        step(1'b0, 12'h000, 1'b1);
        chk("both3_next", 32'(b.data_out), 32'hA04);
        step(1'b0, 12'h000, 1'b1);
        step(1'b0, 12'h000, 1'b1);
        chk("both3_new", 32'(b.data_out), 32'hB00);
        step(1'b0, 12'h000, 1'b0);

        // Simultaneous push/pop while full
        for (int i = 0; i < 8; i++) step(1'b1, 12'(12'hC00 + i), 1'b0);
        step(1'b1, 12'hD00, 1'b1);
        chk("bothf_count", 32'(b.fifo_count), 32'd8);
        chk("bothf_data", 32'(b.data_out), 32'hC00);
        chk("bothf_error", 32'(b.error), 32'd0);
        for (int i = 1; i <= 8; i++) step(1'b0, 12'h000, 1'b1);
        chk("bothf_last", 32'(b.data_out), 32'hD00);
        chk("bothf_empty", 32'(b.empty), 32'd1);

        // Simultaneous push/pop while empty
        step(1'b1, 12'hE00, 1'b1);
        chk("bothe_count", 32'(b.fifo_count), 32'd1);
        chk("bothe_valid", 32'(b.valid_out), 32'd0);
        chk("bothe_error", 32'(b.error), 32'd1);
        step(1'b0, 12'h000, 1'b0);

        // Threshold change takes effect without a clock edge
        b.ae_thresh = 4'd0;
        #1;
        chk("ae_thresh_live", 32'(b.almost_empty), 32'd0);
        b.ae_thresh = 4'd2;

        // Reset with a read in flight
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 12'(12'h200 + i), 1'b0);
        step(1'b0, 12'h000, 1'b1);
        chk("inflight_valid", 32'(b.valid_out), 32'd1);
        b.pop = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(b.valid_out), 32'd0);
        chk("arst_count", 32'(b.fifo_count), 32'd0);
        chk("arst_wr_ptr", 32'(b.wr_ptr), 32'd0);
        chk("arst_rd_ptr", 32'(b.rd_ptr), 32'd0);
        chk("arst_error", 32'(b.error), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 12'h000, 1'b0);
        step(1'b0, 12'h000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
